// File: rtl/tb_mem_pkg.sv
// Shared types, default address map and LFSR step for the bench-memory arbiter.
package tb_mem_pkg;

  typedef enum logic {
    PORT_INSTR = 1'b0,
    PORT_DATA  = 1'b1
  } port_e;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_e;

  typedef struct packed {
    logic  valid;
    port_e port;
    logic  err;
  } resp_t;

  localparam logic [31:0] DEF_I_RAM_LO  = 32'h0000_0080;
  localparam logic [31:0] DEF_I_RAM_HI  = 32'h0003_0080;
  localparam logic [31:0] DEF_D_RAM_LO  = 32'h0003_0080;
  localparam logic [31:0] DEF_EXIT_ADDR = 32'h0004_0000;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

endpackage

// File: rtl/tb_mem_resp_pipe.sv
// Fixed-latency response pipeline: DEPTH-stage shift register of resp_t with an empty flag.
module tb_mem_resp_pipe
  import tb_mem_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic  clk,
  input  logic  reset_n,
  input  resp_t in_resp,
  output resp_t out_resp,
  output logic  empty
);

  resp_t stage [DEPTH];

  // NOTE: this register array is reset, unlike a RAM, because its valid bits are
  // control state: a reset must drop every pending response.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= in_resp;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  always_comb begin
    empty = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      if (stage[i].valid) empty = 1'b0;
    end
  end

  assign out_resp = stage[DEPTH-1];

endmodule

// File: rtl/tb_mem_arbiter.sv
// Round-robin arbiter sharing one bench RAM between the instruction and data OBI ports.
// Optional STALL_INJECT_EN: an LFSR withholds grants on pseudo-random cycles.
module tb_mem_arbiter
  import tb_mem_pkg::*;
#(
  parameter int          RD_LATENCY = 1,
  parameter logic [31:0] I_RAM_LO   = DEF_I_RAM_LO,
  parameter logic [31:0] I_RAM_HI   = DEF_I_RAM_HI,
  parameter logic [31:0] D_RAM_LO   = DEF_D_RAM_LO,
  parameter logic [31:0] EXIT_ADDR  = DEF_EXIT_ADDR
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic        instr_err_o,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic        data_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        exit_o,
  output logic        busy_o
);

  localparam logic [1:0] S_RUN   = RUN;
  localparam logic [1:0] S_DRAIN = DRAIN;
  localparam logic [1:0] S_DONE  = DONE;

  logic [1:0] state;
  port_e      rr_ptr;
  logic       exit_q;
  logic       stall;
  logic       can_grant;
  logic       fetch_err, store_err, exit_store;
  logic       pipe_empty;
  resp_t      resp_in, resp_out;

`ifdef STALL_INJECT_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) lfsr <= LFSR_SEED;
    else          lfsr <= lfsr_next(lfsr);
  end

  assign stall = ~lfsr[0];
`else
  assign stall = 1'b0;
`endif

  // Grants are gated by reset_n so every output is quiet while reset is held.
  assign can_grant   = reset_n && (state == S_RUN) && !stall;
  assign instr_gnt_o = can_grant && instr_req_i && (!data_req_i || rr_ptr == PORT_INSTR);
  assign data_gnt_o  = can_grant && data_req_i && (!instr_req_i || rr_ptr == PORT_DATA);

  assign fetch_err  = (instr_addr_i < I_RAM_LO) || (instr_addr_i >= I_RAM_HI);
  assign store_err  = data_we_i && (data_addr_i < D_RAM_LO);
  assign exit_store = data_we_i && (data_addr_i == EXIT_ADDR);

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = 4'h0;
    mem_addr_o  = 32'h0;
    mem_wdata_o = 32'h0;
    if (instr_gnt_o) begin
      mem_req_o  = !fetch_err;
      mem_be_o   = 4'hF;
      mem_addr_o = instr_addr_i;
    end else if (data_gnt_o) begin
      // Blocked stores and the exit store never reach the RAM.
      mem_req_o   = !store_err && !exit_store;
      mem_we_o    = data_we_i && !store_err && !exit_store;
      mem_be_o    = data_be_i;
      mem_addr_o  = data_addr_i;
      mem_wdata_o = data_wdata_i;
    end
  end

  always_comb begin
    resp_in       = '0;
    resp_in.valid = instr_gnt_o || data_gnt_o;
    resp_in.port  = data_gnt_o ? PORT_DATA : PORT_INSTR;
    resp_in.err   = instr_gnt_o ? fetch_err : (data_gnt_o && store_err);
  end

  tb_mem_resp_pipe #(
    .DEPTH (RD_LATENCY)
  ) u_resp_pipe (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_resp  (resp_in),
    .out_resp (resp_out),
    .empty    (pipe_empty)
  );

  // NOTE: sequential state uses non-blocking assignments so all registers update
  // from the same pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_RUN;
      rr_ptr <= PORT_INSTR;
      exit_q <= 1'b0;
    end else begin
      if (instr_gnt_o)     rr_ptr <= PORT_DATA;
      else if (data_gnt_o) rr_ptr <= PORT_INSTR;

      case (state)
        S_RUN:   if (data_gnt_o && exit_store) state <= S_DRAIN;
        S_DRAIN: if (pipe_empty) state <= S_DONE;
        default: state <= S_DONE;
      endcase

      exit_q <= (state == S_DRAIN) && pipe_empty;
    end
  end

  assign instr_rvalid_o = resp_out.valid && (resp_out.port == PORT_INSTR);
  assign instr_err_o    = instr_rvalid_o && resp_out.err;
  assign data_rvalid_o  = resp_out.valid && (resp_out.port == PORT_DATA);
  assign data_err_o     = data_rvalid_o && resp_out.err;
  assign exit_o         = exit_q;
  assign busy_o         = !pipe_empty;

endmodule

// File: tb/tb_tb_mem_arbiter.sv
// Self-checking bench for tb_mem_arbiter: RD_LATENCY=1 and RD_LATENCY=3 instances share stimulus.
module tb_tb_mem_arbiter;

  localparam logic [31:0] I_LO = 32'h0000_0080;
  localparam logic [31:0] I_HI = 32'h0003_0080;
  localparam logic [31:0] D_LO = 32'h0003_0080;
  localparam logic [31:0] EXIT = 32'h0004_0000;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic ireq = 1'b0, dreq = 1'b0, dwe = 1'b0;
  logic [31:0] iaddr = '0, daddr = '0, wdata = '0;
  logic [3:0]  be = '0;

  logic [1:0] ig, irv, ie, dg, drv, de, mreq, mwe, ext, bsy;
  logic [1:0][3:0]  mbe;
  logic [1:0][31:0] maddr, mwd;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  tb_mem_arbiter #(.RD_LATENCY(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n),
    .instr_req_i(ireq), .instr_addr_i(iaddr), .instr_gnt_o(ig[0]),
    .instr_rvalid_o(irv[0]), .instr_err_o(ie[0]),
    .data_req_i(dreq), .data_we_i(dwe), .data_be_i(be), .data_addr_i(daddr),
    .data_wdata_i(wdata), .data_gnt_o(dg[0]), .data_rvalid_o(drv[0]), .data_err_o(de[0]),
    .mem_req_o(mreq[0]), .mem_we_o(mwe[0]), .mem_be_o(mbe[0]), .mem_addr_o(maddr[0]),
    .mem_wdata_o(mwd[0]), .exit_o(ext[0]), .busy_o(bsy[0])
  );

  tb_mem_arbiter #(.RD_LATENCY(3)) u_dut3 (
    .clk(clk), .reset_n(reset_n),
    .instr_req_i(ireq), .instr_addr_i(iaddr), .instr_gnt_o(ig[1]),
    .instr_rvalid_o(irv[1]), .instr_err_o(ie[1]),
    .data_req_i(dreq), .data_we_i(dwe), .data_be_i(be), .data_addr_i(daddr),
    .data_wdata_i(wdata), .data_gnt_o(dg[1]), .data_rvalid_o(drv[1]), .data_err_o(de[1]),
    .mem_req_o(mreq[1]), .mem_we_o(mwe[1]), .mem_be_o(mbe[1]), .mem_addr_o(maddr[1]),
    .mem_wdata_o(mwd[1]), .exit_o(ext[1]), .busy_o(bsy[1])
  );

  // Reference model: arbitration by rule, responses scheduled by absolute due cycle.
  int m_rr [2];        // 0 = instruction side has priority, 1 = data side
  int m_st [2];        // 0 run, 1 drain, 2 done
  int m_exit_due [2];
  bit sv [2][8];
  bit sp [2][8];
  bit se [2][8];

  typedef struct {
    logic ireq; logic [31:0] iaddr;
    logic dreq; logic dwe; logic [31:0] daddr; logic [3:0] be; logic [31:0] wdata;
    logic e_ig; logic e_dg; logic e_mreq; logic e_mwe;
  } vec_t;

  vec_t tbl [12];

  task automatic check(input string name, input int k, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s inst=%0d cyc=%0d got=%h exp=%h", name, k, cyc, got, exp);
    end
  endtask

  task automatic drive(input logic i_r, input logic [31:0] i_a, input logic d_r,
                       input logic d_w, input logic [31:0] d_a, input logic [3:0] b,
                       input logic [31:0] wd);
    ireq = i_r; iaddr = i_a; dreq = d_r; dwe = d_w; daddr = d_a; be = b; wdata = wd;
  endtask

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      m_rr[k] = 0;
      m_st[k] = 0;
      m_exit_due[k] = -1;
      for (int s = 0; s < 8; s++) begin
        sv[k][s] = 1'b0; sp[k][s] = 1'b0; se[k][s] = 1'b0;
      end
    end
  endtask

  // Compare both instances against the model, advance the model, move to next posedge+1.
  task automatic cycle();
    for (int k = 0; k < 2; k++) begin
      int  lat = (k == 0) ? 1 : 3;
      int  win = -1;
      int  cnt = 0;
      int  slot = cyc % 8;
      bit  ferr = (iaddr < I_LO) || (iaddr >= I_HI);
      bit  serr = dwe && (daddr < D_LO);
      bit  is_exit = dwe && (daddr == EXIT);
      bit  e_mreq, e_mwe;
      if (m_st[k] == 0) begin
        if (ireq && dreq) win = m_rr[k];
        else if (ireq)    win = 0;
        else if (dreq)    win = 1;
      end
      for (int s = 0; s < 8; s++) cnt += int'(sv[k][s]);
      e_mreq = (win == 0 && !ferr) || (win == 1 && !serr && !is_exit);
      e_mwe  = (win == 1) && dwe && !serr && !is_exit;

      check("instr_gnt", k, 32'(ig[k]), 32'(win == 0));
      check("data_gnt", k, 32'(dg[k]), 32'(win == 1));
      check("mem_req", k, 32'(mreq[k]), 32'(e_mreq));
      check("mem_we", k, 32'(mwe[k]), 32'(e_mwe));
      if (e_mreq) begin
        check("mem_addr", k, maddr[k], (win == 0) ? iaddr : daddr);
        check("mem_be", k, 32'(mbe[k]), (win == 0) ? 32'hF : 32'(be));
      end
      if (e_mwe) check("mem_wdata", k, mwd[k], wdata);
      check("instr_rvalid", k, 32'(irv[k]), 32'(sv[k][slot] && !sp[k][slot]));
      check("instr_err", k, 32'(ie[k]), 32'(sv[k][slot] && !sp[k][slot] && se[k][slot]));
      check("data_rvalid", k, 32'(drv[k]), 32'(sv[k][slot] && sp[k][slot]));
      check("data_err", k, 32'(de[k]), 32'(sv[k][slot] && sp[k][slot] && se[k][slot]));
      check("busy", k, 32'(bsy[k]), 32'(cnt > 0));
      check("exit", k, 32'(ext[k]), 32'(cyc == m_exit_due[k]));

      sv[k][slot] = 1'b0;
      if (win >= 0) begin
        sv[k][(cyc + lat) % 8] = 1'b1;
        sp[k][(cyc + lat) % 8] = (win == 1);
        se[k][(cyc + lat) % 8] = (win == 0) ? ferr : serr;
        m_rr[k] = (win == 0) ? 1 : 0;
      end
      if (m_st[k] == 0 && win == 1 && is_exit) begin
        m_st[k] = 1;
      end else if (m_st[k] == 1 && cnt == 0) begin
        m_st[k] = 2;
        m_exit_due[k] = cyc + 1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic tick();
    #2;
    cycle();
  endtask

  task automatic check_quiet();
    for (int k = 0; k < 2; k++) begin
      check("rst_gnt", k, 32'({ig[k], dg[k]}), 32'h0);
      check("rst_rvalid", k, 32'({irv[k], drv[k], ie[k], de[k]}), 32'h0);
      check("rst_mem", k, 32'({mreq[k], mwe[k], mbe[k]}), 32'h0);
      check("rst_addr", k, maddr[k] | mwd[k], 32'h0);
      check("rst_exit_busy", k, 32'({ext[k], bsy[k]}), 32'h0);
    end
  endtask

  // Assert reset now (possibly mid-cycle), check outputs at once, release after posedge+1.
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check_quiet();
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_clear();
  endtask

  function automatic vec_t mk(input logic i_r, input logic [31:0] i_a, input logic d_r,
                              input logic d_w, input logic [31:0] d_a, input logic e_ig,
                              input logic e_dg, input logic e_mreq, input logic e_mwe);
    vec_t v;
    v.ireq = i_r; v.iaddr = i_a; v.dreq = d_r; v.dwe = d_w; v.daddr = d_a;
    v.be = 4'h5; v.wdata = 32'hC0DE_0000 | i_a;
    v.e_ig = e_ig; v.e_dg = e_dg; v.e_mreq = e_mreq; v.e_mwe = e_mwe;
    return v;
  endfunction

  initial begin
    int n_i, n_d, n_rv, n_ex;
    logic [31:0] pool [10];
    pool = '{32'h0, 32'h7C, 32'h80, 32'h100, 32'h2000, 32'h3007C,
             32'h30080, 32'h30084, 32'h40000, 32'h40004};

    // Expected grants/strobes from reset, rr pointer starting at INSTR.
    tbl[0]  = mk(1, 32'h80,    0, 0, 32'h0,     1, 0, 1, 0);
    tbl[1]  = mk(0, 32'h0,     0, 0, 32'h0,     0, 0, 0, 0);
    tbl[2]  = mk(0, 32'h0,     1, 1, 32'h100,   0, 1, 0, 0);
    tbl[3]  = mk(1, 32'h30080, 0, 0, 32'h0,     1, 0, 0, 0);
    tbl[4]  = mk(1, 32'h7C,    0, 0, 32'h0,     1, 0, 0, 0);
    tbl[5]  = mk(1, 32'h200,   1, 0, 32'h40000, 0, 1, 1, 0);
    tbl[6]  = mk(1, 32'h204,   1, 1, 32'h30080, 1, 0, 1, 0);
    tbl[7]  = mk(1, 32'h204,   1, 1, 32'h30080, 0, 1, 1, 1);
    tbl[8]  = mk(0, 32'h0,     1, 1, 32'h3007C, 0, 1, 0, 0);
    tbl[9]  = mk(1, 32'h3007C, 0, 0, 32'h0,     1, 0, 1, 0);
    tbl[10] = mk(0, 32'h0,     1, 0, 32'h10,    0, 1, 1, 0);
    tbl[11] = mk(0, 32'h0,     0, 0, 32'h0,     0, 0, 0, 0);

    #2;
    do_reset();

    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].ireq, tbl[i].iaddr, tbl[i].dreq, tbl[i].dwe, tbl[i].daddr,
            tbl[i].be, tbl[i].wdata);
      #2;
      check($sformatf("tbl%0d_gnt", i), 0, 32'({ig[0], dg[0]}), 32'({tbl[i].e_ig, tbl[i].e_dg}));
      check($sformatf("tbl%0d_mem", i), 0, 32'({mreq[0], mwe[0]}),
            32'({tbl[i].e_mreq, tbl[i].e_mwe}));
      cycle();
    end

    // Continuous contention: grants alternate starting with the fetch side.
    n_i = 0; n_d = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1, 32'h1000 + 32'(4 * i), 1, 0, 32'h30100 + 32'(4 * i), 4'hF, 0);
      #2;
      check("alt_order", 0, 32'({ig[0], dg[0]}), (i % 2 == 0) ? 32'h2 : 32'h1);
      n_i += int'(ig[0]);
      n_d += int'(dg[0]);
      cycle();
    end
    check("alt_instr_cnt", 0, 32'(n_i), 32'd4);
    check("alt_data_cnt", 0, 32'(n_d), 32'd4);

    // Randomised traffic, exit stores excluded.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a_i, a_d;
      logic w;
      a_i = pool[$urandom_range(9)];
      a_d = pool[$urandom_range(9)];
      w = 1'($urandom_range(1));
      if (w && a_d == EXIT) a_d = 32'h30100;
      drive(($urandom_range(9) < 7), a_i, ($urandom_range(9) < 7), w, a_d,
            4'($urandom), $urandom);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (4) tick();

    // Two loads in flight, then the exit store; fetch and load requests held during drain.
    do_reset();
    n_rv = 0; n_ex = 0;
    for (int i = 0; i < 13; i++) begin
      if (i == 0)      drive(0, 0, 1, 0, 32'h30100, 4'hF, 0);
      else if (i == 1) drive(0, 0, 1, 0, 32'h30104, 4'hF, 0);
      else if (i == 2) drive(0, 0, 1, 1, EXIT, 4'hF, 32'h1);
      else             drive(1, 32'h80, 1, 0, 32'h30100, 4'hF, 0);
      #2;
      if (i >= 3) check("drain_no_gnt", 1, 32'({ig[1], dg[1]}), 32'h0);
      n_rv += int'(drv[1]);
      n_ex += int'(ext[1]);
      cycle();
    end
    check("drain_rvalids", 1, 32'(n_rv), 32'd3);
    check("exit_pulses", 1, 32'(n_ex), 32'd1);

    // Exit store against a fetch with the pointer on DATA: store wins, fetch never granted.
    do_reset();
    drive(1, 32'h80, 0, 0, 0, 0, 0);
    tick();
    n_i = 0; n_ex = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1, 32'h84, 1, 1, EXIT, 4'hF, 32'h2);
      #2;
      if (i == 0) check("exit_vs_fetch", 0, 32'({ig[0], dg[0], mreq[0]}), 32'b010);
      n_i += int'(ig[0]);
      n_ex += int'(ext[0]);
      cycle();
    end
    check("fetch_starved", 0, 32'(n_i), 32'd0);
    check("exit_once", 0, 32'(n_ex), 32'd1);

    // Reset with responses in flight: outputs quiet at once and nothing after release.
    do_reset();
    drive(0, 0, 1, 0, 32'h30200, 4'hF, 0);
    tick();
    drive(0, 0, 1, 0, 32'h30204, 4'hF, 0);
    tick();
    check("inflight_busy", 1, 32'(bsy[1]), 32'h1);
    do_reset();
    n_rv = 0;
    for (int i = 0; i < 6; i++) begin
      #2;
      n_rv += int'(drv[0]) + int'(drv[1]) + int'(irv[0]) + int'(irv[1]);
      cycle();
    end
    check("no_resp_after_reset", 1, 32'(n_rv), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
